// File: rtl/cp0_unit_pkg.sv
`default_nettype none
// ============================================================================
// cp0_unit_pkg : CP0 register numbers, bitfield layout and ExcCode values.
// Revision     : 1.0
// ============================================================================
package cp0_unit_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] sr_word(input sr_t s);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LO +: 6] = s.im;
    w[SR_EXL]        = s.exl;
    w[SR_IE]         = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]           = c.bd;
    w[CAUSE_IP_LO +: 6]   = c.ip;
    w[CAUSE_EXC_LO +: 5]  = c.exc_code;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_unit_if.sv
`default_nettype none
// ============================================================================
// cp0_unit_if : M-stage pipeline <-> CP0 signal bundle.
// Revision    : 1.0
// ============================================================================
interface cp0_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        we;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic        Req;

  modport master (
    output A1, A2, Din, we, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  Dout, EPCOut, Req
  );

  modport slave (
    input  A1, A2, Din, we, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output Dout, EPCOut, Req
  );
endinterface
`default_nettype wire

// File: rtl/cp0_req_logic.sv
`default_nettype none
// ============================================================================
// cp0_req_logic : combinational exception/interrupt request decision.
// Revision      : 1.0
// ============================================================================
module cp0_req_logic
  import cp0_unit_pkg::*;
(
  input  wire logic [5:0] i_im,
  input  wire logic       i_ie,
  input  wire logic       i_exl,
  input  wire logic [5:0] i_hw_int,
  input  wire logic [4:0] i_exc_code,
  output logic            o_int_req,
  output logic            o_exc_req,
  output logic            o_req,
  output logic [4:0]      o_exc_code
);

  assign o_int_req  = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
  assign o_exc_req  = (i_exc_code != EXC_INT) & ~i_exl;
  assign o_req      = o_int_req | o_exc_req;
  // Interrupts win over a synchronous exception in the same cycle.
  assign o_exc_code = o_int_req ? EXC_INT : i_exc_code;

endmodule
`default_nettype wire

// File: rtl/cp0_unit.sv
`default_nettype none
// ============================================================================
// cp0_unit : Coprocessor 0 (SR, Cause, EPC, PRId) and exception request.
// Revision : 1.0
// ============================================================================
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2022_0B0A,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input wire logic     clk,
  input wire logic     reset,
  cp0_unit_if.slave    bus
);

  sr_t         r_sr;
  cause_t      r_cause;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic [4:0]  w_exc_code;
  logic [31:0] w_dout;
  logic        w_unused_handler_pc;

  // The handler address lives in the fetch unit; kept here only as a reference value.
  assign w_unused_handler_pc = ^HANDLER_PC;

  cp0_req_logic u_req_logic (
    .i_im       (r_sr.im),
    .i_ie       (r_sr.ie),
    .i_exl      (r_sr.exl),
    .i_hw_int   (bus.HWInt),
    .i_exc_code (bus.ExcCodeIn),
    .o_int_req  (w_int_req),
    .o_exc_req  (w_exc_req),
    .o_req      (w_req),
    .o_exc_code (w_exc_code)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr    <= '0;
      r_cause <= '0;
      r_epc   <= '0;
    end else begin
      r_cause.ip <= bus.HWInt;
      if (w_req) begin
        r_sr.exl         <= 1'b1;
        r_cause.bd       <= bus.BDIn;
        r_cause.exc_code <= w_exc_code;
        r_epc            <= bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
      end else begin
        if (bus.we) begin
          case (bus.A2)
            CP0_REG_SR: begin
              r_sr.im  <= bus.Din[SR_IM_LO +: 6];
              r_sr.exl <= bus.Din[SR_EXL];
              r_sr.ie  <= bus.Din[SR_IE];
            end
            CP0_REG_EPC: r_epc <= bus.Din;
            default: ;
          endcase
        end
        // eret clear is issued after the write so it overrides a written EXL.
        if (bus.EXLClr) begin
          r_sr.exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_dout = '0;
    case (bus.A1)
      CP0_REG_SR:    w_dout = sr_word(r_sr);
      CP0_REG_CAUSE: w_dout = cause_word(r_cause);
      CP0_REG_EPC:   w_dout = r_epc;
      CP0_REG_PRID:  w_dout = PRID_VAL;
      default:       w_dout = '0;
    endcase
  end

  assign bus.Dout   = w_dout;
  assign bus.EPCOut = r_epc;
  assign bus.Req    = w_req;

  logic w_unused_req_parts;
  assign w_unused_req_parts = w_int_req ^ w_exc_req;

endmodule
`default_nettype wire

// File: tb/tb_cp0_unit.sv
`default_nettype none
// Self-checking bench for cp0_unit: directed vector table, random run against
// a word-level register model, and a reset-dominance sequence.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h2022_0B0A;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  cp0_unit_if bus();

  cp0_unit #(.PRID_VAL(PRID), .HANDLER_PC(32'h0000_4180)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic [31:0] dout;
    logic        req;
    logic [31:0] epc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                              input logic we, input logic [31:0] vpc, input logic bd,
                              input logic [4:0] exc, input logic [5:0] hw, input logic clr,
                              input logic [31:0] dout, input logic req, input logic [31:0] epc);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.din = din; v.we = we; v.vpc = vpc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.clr = clr; v.dout = dout; v.req = req; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                       input logic we, input logic [31:0] vpc, input logic bd,
                       input logic [4:0] exc, input logic [5:0] hw, input logic clr);
    bus.A1 = a1; bus.A2 = a2; bus.Din = din; bus.we = we; bus.VPC = vpc;
    bus.BDIn = bd; bus.ExcCodeIn = exc; bus.HWInt = hw; bus.EXLClr = clr;
  endtask

  // Word-level reference model
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int(input logic [5:0] hw);
    return (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req(input logic [5:0] hw, input logic [4:0] exc);
    return m_int(hw) || ((exc != 5'd0) && !m_sr[1]);
  endfunction

  task automatic m_step(input logic rst, input logic [4:0] a2, input logic [31:0] din,
                        input logic we, input logic [31:0] vpc, input logic bd,
                        input logic [4:0] exc, input logic [5:0] hw, input logic clr);
    logic [31:0] code;
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else if (m_req(hw, exc)) begin
      code    = m_int(hw) ? 32'd0 : {27'd0, exc};
      m_cause = ({31'd0, bd} << 31) | ({26'd0, hw} << 10) | (code << 2);
      m_epc   = bd ? vpc - 32'd4 : vpc;
      m_sr    = m_sr | 32'h2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
      if (we && a2 == 5'd12) m_sr  = din & 32'h0000_FC03;
      if (we && a2 == 5'd14) m_epc = din;
      if (clr) m_sr = m_sr & ~32'h2;
    end
  endtask

  initial begin
    logic [4:0] a1, a2, exc;
    logic [31:0] din, vpc;
    logic we, bd, clr, rst;
    logic [5:0] hw;

    reset = 1'b1;
    drive(5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //          a1  a2  din            we vpc           bd exc    hw         clr  dout           req  epc
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(15, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, PRID,          0, 32'h0));
    vq.push_back(mk(16, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(12, 12, 32'h0000_FC01, 1, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h0));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h1000,     0, 5'd0,  6'b000100, 0, 32'h0000_FC01, 1, 32'h0));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000100, 0, 32'h0000_1000, 0, 32'h1000));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000100, 0, 32'h0000_1000, 0, 32'h1000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000100, 0, 32'h0000_FC03, 0, 32'h1000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000100, 1, 32'h0000_FC03, 0, 32'h1000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h2000,     0, 5'd0,  6'b000100, 0, 32'h0000_FC01, 1, 32'h1000));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_2000, 0, 32'h2000));
    vq.push_back(mk(13, 12, 32'h0000_FC00, 1, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h2000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h3010,     1, 5'd12, 6'b000000, 0, 32'h0000_FC00, 1, 32'h2000));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h8000_0030, 0, 32'h300C));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_300C, 0, 32'h300C));
    vq.push_back(mk(12, 12, 32'h0000_0401, 1, 32'h0,        0, 5'd0,  6'b000000, 1, 32'h0000_FC02, 0, 32'h300C));
    vq.push_back(mk(12, 14, 32'hDEAD_BEEF, 1, 32'h4000,     0, 5'd4,  6'b000001, 0, 32'h0000_0401, 1, 32'h300C));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_4000, 0, 32'h4000));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0,         0, 32'h4000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h0,        0, 5'd10, 6'b000000, 1, 32'h0000_0403, 0, 32'h4000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h5000,     0, 5'd10, 6'b000000, 1, 32'h0000_0401, 1, 32'h4000));
    vq.push_back(mk(12, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_0403, 0, 32'h5000));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_0028, 0, 32'h5000));
    vq.push_back(mk(13, 13, 32'hFFFF_FFFF, 1, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_0028, 0, 32'h5000));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_0028, 0, 32'h5000));
    vq.push_back(mk(12, 12, 32'hFFFF_FFFF, 1, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_0403, 0, 32'h5000));
    vq.push_back(mk(12, 15, 32'h0,         1, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h0000_FC03, 0, 32'h5000));
    vq.push_back(mk(15, 14, 32'h1234_5678, 1, 32'h0,        0, 5'd0,  6'b000000, 0, PRID,          0, 32'h5000));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h1234_5678, 0, 32'h1234_5678));
    vq.push_back(mk(0,  0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 1, 32'h0,         0, 32'h1234_5678));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        1, 5'd5,  6'b000000, 0, 32'h1234_5678, 1, 32'h1234_5678));
    vq.push_back(mk(14, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC));
    vq.push_back(mk(13, 0,  32'h0,         0, 32'h0,        0, 5'd0,  6'b000000, 0, 32'h8000_0014, 0, 32'hFFFF_FFFC));

    foreach (vq[i]) begin
      drive(vq[i].a1, vq[i].a2, vq[i].din, vq[i].we, vq[i].vpc, vq[i].bd,
            vq[i].exc, vq[i].hw, vq[i].clr);
      #1;
      chk($sformatf("vec%0d_dout", i), bus.Dout, vq[i].dout);
      chk($sformatf("vec%0d_req", i), {31'd0, bus.Req}, {31'd0, vq[i].req});
      chk($sformatf("vec%0d_epc", i), bus.EPCOut, vq[i].epc);
      @(posedge clk);
      #1;
    end

    // Random phase, synchronised to the model through a reset
    reset = 1'b1;
    drive(5'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    m_step(1'b1, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      a1  = 5'($urandom_range(10, 17));
      case ($urandom_range(0, 4))
        0: a2 = 5'd12;
        1: a2 = 5'd13;
        2: a2 = 5'd14;
        3: a2 = 5'd15;
        default: a2 = 5'($urandom);
      endcase
      din = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0000_FC01;
      we  = ($urandom_range(0, 2) == 0);
      vpc = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      bd  = 1'($urandom);
      exc = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      hw  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      clr = ($urandom_range(0, 5) == 0);
      reset = rst;
      drive(a1, a2, din, we, vpc, bd, exc, hw, clr);
      #1;
      chk("rnd_dout", bus.Dout, m_read(a1));
      chk("rnd_req", {31'd0, bus.Req}, {31'd0, m_req(hw, exc)});
      chk("rnd_epc", bus.EPCOut, m_epc);
      m_step(rst, a2, din, we, vpc, bd, exc, hw, clr);
      @(posedge clk);
      #1;
    end

    // Reset dominates a pending exception, interrupt and mtc0
    reset = 1'b0;
    drive(5'd12, 5'd12, 32'h0000_FC01, 1'b1, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(5'd12, 5'd14, 32'hCAFE_F00D, 1'b1, 32'h7000, 1'b1, 5'd12, 6'h3F, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(5'd12, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    #1 chk("rstdom_sr", bus.Dout, 32'h0);
    chk("rstdom_req", {31'd0, bus.Req}, 32'h0);
    bus.A1 = 5'd13;
    #1 chk("rstdom_cause", bus.Dout, 32'h0);
    bus.A1 = 5'd14;
    #1 chk("rstdom_epc", bus.Dout, 32'h0);
    chk("rstdom_epcout", bus.EPCOut, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
